brick_hit_detect: RTL and testbench

BRICK_HIT_DETECT -- requirements
Module: brick_hit_detect

---
 rtl/brick_hit_detect.sv | 118 +++++++++++
 tb/tb_brick_hit_detect.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/brick_hit_detect.sv
// brick_hit_detect: 8x4 brick grid, two-probe hit test with health tracking; optional BRICK_ROW_HEALTH_EN loads per-row health
module brick_hit_detect #(
  parameter logic [9:0] GRID_X0 = 10'd16,
  parameter logic [9:0] GRID_Y0 = 10'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] probe_x1,
  input  logic [9:0] probe_y1,
  input  logic [9:0] probe_x2,
  input  logic [9:0] probe_y2,
  output logic [9:0] col_x1,
  output logic [9:0] col_y1,
  output logic [9:0] col_x2,
  output logic [9:0] col_y2,
  output logic [1:0] col_health1,
  output logic [1:0] col_health2,
  output logic       collided_1,
  output logic       collided_2,
  output logic       done,
  output logic       busy,
  output logic [5:0] bricks_left
);
  typedef enum logic [2:0] {INIT, IDLE, CHECK1, UPDATE1, CHECK2, UPDATE2, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [1:0] health [32];
  logic [9:0] px1, py1, px2, py2;
  logic [9:0] dx1, dy1, dx2, dy2;
  logic in1, in2, hit1, hit2;
  logic [4:0] idx1, idx2;
  logic [1:0] h1, h2, init_h;
`ifdef BRICK_ROW_HEALTH_EN
  assign init_h = (cnt[4:3] == 2'd3) ? 2'd1 : (cnt[4:3] == 2'd2) ? 2'd2 : 2'd3;
`else
  assign init_h = 2'd1;
`endif
  // x >= origin guarantees the subtraction does not wrap, so the upper bound is a plain compare
  assign dx1 = px1 - GRID_X0;
  assign dy1 = py1 - GRID_Y0;
  assign dx2 = px2 - GRID_X0;
  assign dy2 = py2 - GRID_Y0;
  assign in1 = px1 >= GRID_X0 && dx1 < 10'd128 && py1 >= GRID_Y0 && dy1 < 10'd32;
  assign in2 = px2 >= GRID_X0 && dx2 < 10'd128 && py2 >= GRID_Y0 && dy2 < 10'd32;
  assign idx1 = {dy1[4:3], dx1[6:4]};
  assign idx2 = {dy2[4:3], dx2[6:4]};
  assign h1 = health[idx1];
  assign h2 = health[idx2];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      cnt         <= 5'd0;
      hit1        <= 1'b0;
      hit2        <= 1'b0;
      collided_1  <= 1'b0;
      collided_2  <= 1'b0;
      col_x1      <= 10'd0;
      col_y1      <= 10'd0;
      col_x2      <= 10'd0;
      col_y2      <= 10'd0;
      col_health1 <= 2'd0;
      col_health2 <= 2'd0;
      done        <= 1'b0;
      bricks_left <= 6'd32;
    end else begin
      done <= state == UPDATE2;
      case (state)
        INIT: begin
          health[cnt] <= init_h;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= IDLE;
        end
        IDLE: if (start) begin
          px1 <= probe_x1;
          py1 <= probe_y1;
          px2 <= probe_x2;
          py2 <= probe_y2;
          state <= CHECK1;
        end
        CHECK1: begin
          hit1 <= in1 && h1 != 2'd0;
          state <= UPDATE1;
        end
        UPDATE1: begin
          collided_1  <= hit1;
          col_x1      <= hit1 ? GRID_X0 + {3'd0, dx1[6:4], 4'd0} : 10'd0;
          col_y1      <= hit1 ? GRID_Y0 + {5'd0, dy1[4:3], 3'd0} : 10'd0;
          col_health1 <= hit1 ? h1 - 2'd1 : 2'd0;
          if (hit1) begin
            health[idx1] <= h1 - 2'd1;
            if (h1 == 2'd1 && bricks_left != 6'd0) bricks_left <= bricks_left - 6'd1;
          end
          state <= CHECK2;
        end
        CHECK2: begin
          // a brick already struck by probe 1 this round is not struck again
          hit2 <= in2 && h2 != 2'd0 && !(hit1 && idx1 == idx2);
          state <= UPDATE2;
        end
        UPDATE2: begin
          collided_2  <= hit2;
          col_x2      <= hit2 ? GRID_X0 + {3'd0, dx2[6:4], 4'd0} : 10'd0;
          col_y2      <= hit2 ? GRID_Y0 + {5'd0, dy2[4:3], 3'd0} : 10'd0;
          col_health2 <= hit2 ? h2 - 2'd1 : 2'd0;
          if (hit2) begin
            health[idx2] <= h2 - 2'd1;
            if (h2 == 2'd1 && bricks_left != 6'd0) bricks_left <= bricks_left - 6'd1;
          end
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_brick_hit_detect.sv
// tb_brick_hit_detect: directed checks of hit/miss, same-brick, destruction, boundaries and start/reset interlocks
module tb_brick_hit_detect;
`ifdef BRICK_ROW_HEALTH_EN
  localparam bit ROWH = 1'b1;
`else
  localparam bit ROWH = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [9:0] probe_x1 = '0, probe_y1 = '0, probe_x2 = '0, probe_y2 = '0;
  logic [9:0] col_x1, col_y1, col_x2, col_y2;
  logic [1:0] col_health1, col_health2;
  logic collided_1, collided_2, done, busy;
  logic [5:0] bricks_left;
  int n_cmp = 0, n_bad = 0;
  brick_hit_detect dut (
    .clk(clk), .reset(reset), .start(start),
    .probe_x1(probe_x1), .probe_y1(probe_y1), .probe_x2(probe_x2), .probe_y2(probe_y2),
    .col_x1(col_x1), .col_y1(col_y1), .col_x2(col_x2), .col_y2(col_y2),
    .col_health1(col_health1), .col_health2(col_health2),
    .collided_1(collided_1), .collided_2(collided_2),
    .done(done), .busy(busy), .bricks_left(bricks_left)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // lat = edges after the start-sampling edge until done is seen (DONE is the 5th cycle)
  task automatic go(input logic [9:0] x1, y1, x2, y2, output int lat);
    for (int i = 0; i < 40 && busy; i++) tick();
    probe_x1 = x1; probe_y1 = y1; probe_x2 = x2; probe_y2 = y2;
    start = 1'b1;
    tick();
    start = 1'b0;
    probe_x1 = 10'd20; probe_y1 = 10'd18; probe_x2 = 10'd143; probe_y2 = 10'd47;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got %0d want 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %0d want 0", done); end
    n_cmp++; if ({collided_1, collided_2} !== 2'b00) begin n_bad++; $display("FAIL rst_coll got %b want 00", {collided_1, collided_2}); end
    n_cmp++; if ({col_x1, col_y1, col_x2, col_y2, col_health1, col_health2} !== 44'd0) begin n_bad++; $display("FAIL rst_col got %h want 0", {col_x1, col_y1, col_x2, col_y2, col_health1, col_health2}); end
    n_cmp++; if (bricks_left !== 6'd32) begin n_bad++; $display("FAIL rst_bricks got %0d want 32", bricks_left); end
    reset = 1'b0;
    repeat (31) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL init31_busy got %0d want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL init32_busy got %0d want 0", busy); end
  endtask
  task automatic test_hit_miss();
    int lat;
    go(10'd20, 10'd18, 10'd200, 10'd100, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL hm_latency got %0d want 4", lat); end
    n_cmp++; if (collided_1 !== 1'b1) begin n_bad++; $display("FAIL hm_c1 got %0d want 1", collided_1); end
    n_cmp++; if (col_x1 !== 10'd16 || col_y1 !== 10'd16) begin n_bad++; $display("FAIL hm_xy1 got %0d,%0d want 16,16", col_x1, col_y1); end
    n_cmp++; if (col_health1 !== (ROWH ? 2'd2 : 2'd0)) begin n_bad++; $display("FAIL hm_h1 got %0d want %0d", col_health1, ROWH ? 2 : 0); end
    n_cmp++; if (collided_2 !== 1'b0 || col_x2 !== 10'd0) begin n_bad++; $display("FAIL hm_c2 got %0d,%0d want 0,0", collided_2, col_x2); end
    n_cmp++; if (bricks_left !== (ROWH ? 6'd32 : 6'd31)) begin n_bad++; $display("FAIL hm_bricks got %0d want %0d", bricks_left, ROWH ? 32 : 31); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL hm_pulse got done=%0d busy=%0d want 0,0", done, busy); end
    tick(); tick();
    n_cmp++; if (collided_1 !== 1'b1 || col_x1 !== 10'd16) begin n_bad++; $display("FAIL hm_hold got %0d,%0d want 1,16", collided_1, col_x1); end
  endtask
  task automatic test_same_brick();
    int lat;
    go(10'd40, 10'd26, 10'd41, 10'd27, lat);
    n_cmp++; if (collided_1 !== 1'b1) begin n_bad++; $display("FAIL sb_c1 got %0d want 1", collided_1); end
    n_cmp++; if (col_x1 !== 10'd32 || col_y1 !== 10'd24) begin n_bad++; $display("FAIL sb_xy1 got %0d,%0d want 32,24", col_x1, col_y1); end
    n_cmp++; if (col_health1 !== (ROWH ? 2'd2 : 2'd0)) begin n_bad++; $display("FAIL sb_h1 got %0d want %0d", col_health1, ROWH ? 2 : 0); end
    n_cmp++; if (collided_2 !== 1'b0) begin n_bad++; $display("FAIL sb_c2 got %0d want 0", collided_2); end
    n_cmp++; if (bricks_left !== (ROWH ? 6'd32 : 6'd30)) begin n_bad++; $display("FAIL sb_bricks got %0d want %0d", bricks_left, ROWH ? 32 : 30); end
  endtask
  task automatic test_destroy();
    int lat;
    go(10'd16, 10'd40, 10'd0, 10'd0, lat);
    n_cmp++; if (collided_1 !== 1'b1 || col_health1 !== 2'd0) begin n_bad++; $display("FAIL ds_hit got %0d,%0d want 1,0", collided_1, col_health1); end
    n_cmp++; if (bricks_left !== (ROWH ? 6'd31 : 6'd29)) begin n_bad++; $display("FAIL ds_bricks got %0d want %0d", bricks_left, ROWH ? 31 : 29); end
    go(10'd16, 10'd40, 10'd0, 10'd0, lat);
    n_cmp++; if (collided_1 !== 1'b0 || col_x1 !== 10'd0 || col_health1 !== 2'd0) begin n_bad++; $display("FAIL ds_again got %0d,%0d,%0d want 0,0,0", collided_1, col_x1, col_health1); end
    n_cmp++; if (bricks_left !== (ROWH ? 6'd31 : 6'd29)) begin n_bad++; $display("FAIL ds_again_bricks got %0d want %0d", bricks_left, ROWH ? 31 : 29); end
  endtask
  task automatic test_boundary();
    int lat;
    go(10'd144, 10'd20, 10'd143, 10'd47, lat);
    n_cmp++; if (collided_1 !== 1'b0) begin n_bad++; $display("FAIL bd_c1 got %0d want 0", collided_1); end
    n_cmp++; if (collided_2 !== 1'b1) begin n_bad++; $display("FAIL bd_c2 got %0d want 1", collided_2); end
    n_cmp++; if (col_x2 !== 10'd128 || col_y2 !== 10'd40) begin n_bad++; $display("FAIL bd_xy2 got %0d,%0d want 128,40", col_x2, col_y2); end
    n_cmp++; if (col_health2 !== 2'd0) begin n_bad++; $display("FAIL bd_h2 got %0d want 0", col_health2); end
    n_cmp++; if (bricks_left !== (ROWH ? 6'd30 : 6'd28)) begin n_bad++; $display("FAIL bd_bricks got %0d want %0d", bricks_left, ROWH ? 30 : 28); end
    go(10'd15, 10'd16, 10'd16, 10'd15, lat);
    n_cmp++; if ({collided_1, collided_2} !== 2'b00) begin n_bad++; $display("FAIL bd_low got %b want 00", {collided_1, collided_2}); end
  endtask
  task automatic test_start_ignored();
    int n_done = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      start = (i >= 4 && i < 12);
      tick();
      n_done += int'(done);
    end
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL si_init_busy got %0d want 0", busy); end
    n_cmp++; if (bricks_left !== 6'd32) begin n_bad++; $display("FAIL si_bricks got %0d want 32", bricks_left); end
    repeat (10) begin tick(); n_done += int'(done); end
    n_cmp++; if (n_done !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL si_init_start got done=%0d busy=%0d want 0,0", n_done, busy); end
    probe_x1 = 10'd0; probe_y1 = 10'd0; probe_x2 = 10'd0; probe_y2 = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) begin tick(); n_done += int'(done); end
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL si_check2_dones got %0d want 1", n_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL si_check2_busy got %0d want 0", busy); end
  endtask
  task automatic test_reset_update1();
    int lat;
    probe_x1 = 10'd20; probe_y1 = 10'd18; probe_x2 = 10'd0; probe_y2 = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ru_busy got busy=%0d done=%0d want 1,0", busy, done); end
    n_cmp++; if (collided_1 !== 1'b0 || bricks_left !== 6'd32) begin n_bad++; $display("FAIL ru_out got %0d,%0d want 0,32", collided_1, bricks_left); end
    repeat (31) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ru_init31 got %0d want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ru_init32 got %0d want 0", busy); end
    go(10'd20, 10'd18, 10'd0, 10'd0, lat);
    n_cmp++; if (collided_1 !== 1'b1 || col_health1 !== (ROWH ? 2'd2 : 2'd0)) begin n_bad++; $display("FAIL ru_restored got %0d,%0d want 1,%0d", collided_1, col_health1, ROWH ? 2 : 0); end
    n_cmp++; if (bricks_left !== (ROWH ? 6'd32 : 6'd31)) begin n_bad++; $display("FAIL ru_bricks got %0d want %0d", bricks_left, ROWH ? 32 : 31); end
  endtask
  initial begin
    test_reset();
    test_hit_miss();
    test_same_brick();
    test_destroy();
    test_boundary();
    test_start_ignored();
    test_reset_update1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
